// File: rtl/raw_memory_ctrl.sv
// raw_memory_ctrl: circular raw-buffer sequencer with an L1A event queue and valid/ready readout.
// Optional event numbering is enabled by defining RAW_MEMORY_CTRL_EVCNT_EN.
`default_nettype none

module raw_memory_ctrl #(
    parameter int EVQ_DEPTH = 8,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          l1a,
    input  logic [AW-1:0] l1a_delay,
    input  logic [AW-1:0] wblock,
    input  logic          full,
    output logic [AW-1:0] adw,
    output logic          we,
    output logic [AW-1:0] adr,
    output logic [AW-1:0] adb,
    output logic          rd_valid,
    output logic          rd_first,
    output logic          rd_last,
    input  logic          rd_ready,
    output logic [11:0]   evt_num,
    output logic [7:0]    drop_cnt,
    output logic          busy
);

    localparam int QW = (EVQ_DEPTH > 1) ? $clog2(EVQ_DEPTH) : 1;
    localparam logic [QW:0] QFULL = (QW+1)'(EVQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [AW-1:0] q_start [EVQ_DEPTH];
    logic [AW-1:0] q_len   [EVQ_DEPTH];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   q_count;

    logic [AW-1:0] word_cnt;
    logic [AW-1:0] cur_start;
    logic          first_word;

    logic accept, pop, q_empty, handshake;

    assign we        = run && !full;
    assign q_empty   = (q_count == '0);
    assign accept    = l1a && run && !full && (q_count != QFULL);
    assign pop       = (state == S_LOAD);
    assign rd_valid  = (state == S_READ);
    assign rd_first  = rd_valid && first_word;
    assign rd_last   = rd_valid && (word_cnt == AW'(1));
    assign handshake = rd_valid && rd_ready;
    assign busy      = !q_empty || (state != S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (!q_empty) state_nx = S_LOAD;
            S_LOAD: state_nx = S_READ;
            S_READ: if (handshake && rd_last) state_nx = q_empty ? S_IDLE : S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // Queue payload needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_start[wr_ptr] <= adw - l1a_delay;
            q_len[wr_ptr]   <= (wblock == '0) ? AW'(1) : wblock;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            adw        <= '0;
            adr        <= '0;
            adb        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            word_cnt   <= '0;
            cur_start  <= '0;
            first_word <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (we) adw <= adw + AW'(1);

            if (accept) wr_ptr <= wr_ptr + QW'(1);
            if (pop)    rd_ptr <= rd_ptr + QW'(1);
            case ({accept, pop})
                2'b10:   q_count <= q_count + (QW+1)'(1);
                2'b01:   q_count <= q_count - (QW+1)'(1);
                default: q_count <= q_count;
            endcase

            if (l1a && !accept && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

            if (pop) begin
                adr        <= q_start[rd_ptr];
                cur_start  <= q_start[rd_ptr];
                word_cnt   <= q_len[rd_ptr];
                first_word <= 1'b1;
            end else if (handshake) begin
                adr        <= adr + AW'(1);
                word_cnt   <= word_cnt - AW'(1);
                first_word <= 1'b0;
            end

            // adb protects the oldest word still needed by pending or active readout.
            if (q_empty && (state == S_IDLE)) adb <= adw - l1a_delay;
            else if (state == S_READ)         adb <= cur_start;
            else                              adb <= q_start[rd_ptr];
        end
    end

`ifdef RAW_MEMORY_CTRL_EVCNT_EN
    logic [11:0] evt_ctr;
    logic [11:0] q_evt [EVQ_DEPTH];

    always_ff @(posedge clk) begin
        if (accept) q_evt[wr_ptr] <= evt_ctr + 12'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_ctr <= '0;
            evt_num <= '0;
        end else begin
            if (accept) evt_ctr <= evt_ctr + 12'd1;
            if (pop)    evt_num <= q_evt[rd_ptr];
        end
    end
`else
    assign evt_num = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_raw_memory_ctrl.sv
// tb_raw_memory_ctrl: directed scenarios plus random traffic checked against an event-level model.
`default_nettype none

module tb_raw_memory_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst, run, l1a, full, rd_ready;
    logic [AW-1:0] l1a_delay, wblock;
    logic [AW-1:0] adw, adr, adb;
    logic          we, rd_valid, rd_first, rd_last, busy;
    logic [11:0]   evt_num;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    raw_memory_ctrl #(.EVQ_DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .run(run), .l1a(l1a), .l1a_delay(l1a_delay),
        .wblock(wblock), .full(full), .adw(adw), .we(we), .adr(adr), .adb(adb),
        .rd_valid(rd_valid), .rd_first(rd_first), .rd_last(rd_last),
        .rd_ready(rd_ready), .evt_num(evt_num), .drop_cnt(drop_cnt), .busy(busy)
    );

    typedef struct {
        logic [7:0]  start;
        int          len;
        logic [11:0] evn;
    } ev_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the list of accepted-but-unfinished events.
    ev_t         evq[$];
    int          idx, done_cnt, cyc, last_end_cyc;
    bit          started, prev_idle, gap_chk;
    logic [7:0]  adw_m, drop_m, prev_adw, prev_delay;
    logic [11:0] evcnt_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Queue occupancy bounds: the head leaves the queue one cycle before its first word shows.
    function automatic int qcnt_upper();
        return evq.size() - (started ? 1 : 0);
    endfunction
    function automatic int qcnt_lower();
        return (evq.size() > 0) ? evq.size() - 1 : 0;
    endfunction

    task automatic tick();
        bit         can_acc, hs, idle_now;
        ev_t        e, n;
        logic [7:0] exp_a, exp_b;
        #1;
        idle_now = (evq.size() == 0);
        check_val("adw", adw, adw_m);
        check_val("we", we, run && !full);
        check_val("busy", busy, !idle_now);
        check_val("drop_cnt", drop_cnt, drop_m);
        if (prev_idle) begin
            exp_b = prev_adw - prev_delay;
            check_val("adb_idle", adb, exp_b);
        end
        hs = 1'b0;
        if (rd_valid) begin
            if (evq.size() == 0) begin
                check_val("rd_valid_spurious", rd_valid, 0);
            end else begin
                started = 1'b1;
                e = evq[0];
                exp_a = e.start + 8'(idx);
                check_val("adr", adr, exp_a);
                check_val("adb_read", adb, e.start);
                check_val("rd_first", rd_first, idx == 0);
                check_val("rd_last", rd_last, idx == e.len - 1);
                check_val("evt_num", evt_num, e.evn);
                if (gap_chk && idx == 0 && last_end_cyc >= 0) begin
                    check_val("b2b_gap", cyc - last_end_cyc, 2);
                    last_end_cyc = -1;
                end
                hs = rd_ready;
            end
        end
        can_acc = run && !full;
        if (l1a) begin
            if (!can_acc || qcnt_lower() >= DEPTH) begin
                if (drop_m != 8'hFF) drop_m++;
            end else if (qcnt_upper() < DEPTH) begin
                n.start = adw_m - l1a_delay;
                n.len   = (wblock == 0) ? 1 : int'(wblock);
`ifdef RAW_MEMORY_CTRL_EVCNT_EN
                n.evn   = evcnt_m + 12'd1;
`else
                n.evn   = 12'd0;
`endif
                evcnt_m++;
                evq.push_back(n);
            end else begin
                failures++;
                $display("FAIL stim_ambiguous_l1a queue=%0d depth=%0d", evq.size(), DEPTH);
            end
        end
        if (hs) begin
            idx++;
            if (idx == evq[0].len) begin
                void'(evq.pop_front());
                idx = 0;
                started = 1'b0;
                done_cnt++;
                if (gap_chk) last_end_cyc = cyc;
            end
        end
        prev_idle  = idle_now;
        prev_adw   = adw_m;
        prev_delay = l1a_delay;
        if (can_acc) adw_m++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; l1a = 1'b0; full = 1'b0; rd_ready = 1'b0;
        #1;
        check_val("rst_adw", adw, 0);
        check_val("rst_adr", adr, 0);
        check_val("rst_adb", adb, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_last", rd_last, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_drop", drop_cnt, 0);
        check_val("rst_evt", evt_num, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        evq.delete();
        idx = 0; started = 1'b0; prev_idle = 1'b0;
        adw_m = '0; drop_m = '0; evcnt_m = '0;
    endtask

    task automatic pulse(input logic [7:0] dly, input logic [7:0] wb);
        l1a_delay = dly; wblock = wb; l1a = 1'b1;
        tick();
        l1a = 1'b0;
    endtask

    initial begin
        int guard;
        l1a_delay = '0; wblock = '0; cyc = 0; gap_chk = 1'b0; last_end_cyc = -1; done_cnt = 0;
        @(negedge clk);
        do_reset();

        // Basic event after 20 written words
        run = 1'b1; rd_ready = 1'b1; l1a_delay = 8'd5; wblock = 8'd4;
        repeat (20) tick();
        check_val("t1_adw20", adw, 20);
        pulse(8'd5, 8'd4);
        repeat (10) tick();
        check_val("t1_idle", busy, 0);

        // Start address wraps below zero
        do_reset();
        run = 1'b1; rd_ready = 1'b1;
        repeat (2) tick();
        pulse(8'd6, 8'd3);
        repeat (10) tick();

        // Backpressure mid-event
        pulse(8'd3, 8'd4);
        repeat (4) tick();
        rd_ready = 1'b0;
        repeat (3) begin
            tick();
            check_val("t3_hold_valid", rd_valid, 1);
        end
        rd_ready = 1'b1;
        repeat (8) tick();

        // Queue overflow with one event stalled in readout, then back-to-back drain
        do_reset();
        run = 1'b1; rd_ready = 1'b0; done_cnt = 0;
        pulse(8'd4, 8'd2);
        repeat (3) tick();
        repeat (DEPTH + 1) pulse(8'd4, 8'd2);
        check_val("t4_drop", drop_cnt, 1);
        check_val("t4_busy", busy, 1);
        gap_chk = 1'b1; rd_ready = 1'b1;
        guard = 0;
        while (evq.size() != 0 && guard < 200) begin tick(); guard++; end
        gap_chk = 1'b0;
        check_val("t4_events", done_cnt, DEPTH + 1);

        // Buffer full stalls writing and drops triggers
        do_reset();
        run = 1'b1; rd_ready = 1'b1;
        repeat (5) tick();
        full = 1'b1;
        pulse(8'd2, 8'd2);
        repeat (2) tick();
        check_val("t5_adw_hold", adw, 5);
        check_val("t5_drop", drop_cnt, 1);
        full = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a readout
        pulse(8'd1, 8'd6);
        guard = 0;
        while (!rd_valid && guard < 20) begin tick(); guard++; end
        check_val("t6_wait_valid", rd_valid, 1);
        tick();
        do_reset();
        run = 1'b1; rd_ready = 1'b1;
        repeat (3) tick();
        repeat (3) begin
            pulse(8'd2, 8'd2);
            repeat (4) tick();
        end
        repeat (6) tick();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            run       = ($urandom % 16) != 0;
            full      = ($urandom % 10) == 0;
            rd_ready  = ($urandom % 4) != 0;
            l1a_delay = 8'($urandom);
            wblock    = 8'($urandom % 7);
            l1a       = ($urandom % 5) == 0;
            if (l1a && run && !full && qcnt_upper() >= DEPTH && qcnt_lower() < DEPTH) l1a = 1'b0;
            tick();
        end
        l1a = 1'b0; full = 1'b0; rd_ready = 1'b1;
        guard = 0;
        while (evq.size() != 0 && guard < 2000) begin tick(); guard++; end
        tick();
        check_val("drain_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
